// File: rtl/dac_table_8x_wd_pkg.sv
// Shared types and helpers for the dac_table_8x deadlock watchdog.
// Holds the FSM state encoding, default widths and the saturating increment.
package dac_table_8x_wd_pkg;

   localparam int TIMEOUT_W_DEF = 16;
   localparam int EVT_W_DEF     = 8;
   localparam int NUM_AXIS_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WATCH   = 2'd1,
      TRIPPED = 2'd2
   } wd_state_e;

   // Counters narrower than 32 bits are zero-extended in and truncated back out by the caller.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
      logic [31:0] res;
      if (value >= max_val) begin
         res = max_val;
      end else begin
         res = value + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/dac_table_8x_sat_counter.sv
// Saturating up-counter with a synchronous restart and a combinational look-ahead output.
// clr_i with inc_i loads one, so a fresh run can start on the same cycle the old one ends.
module dac_table_8x_sat_counter
   import dac_table_8x_wd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] count_next_o
);

   localparam logic [31:0] MAX_C = (32'd1 << WIDTH) - 32'd1;

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_inc_s;

   always_comb begin
      count_inc_s = WIDTH'(sat_inc(32'(count_q), MAX_C));
      count_d     = count_q;
      if (clr_i) begin
         if (inc_i) begin
            count_d = {{(WIDTH-1){1'b0}}, 1'b1};
         end else begin
            count_d = {WIDTH{1'b0}};
         end
      end else begin
         if (inc_i) begin
            count_d = count_inc_s;
         end else begin
            count_d = count_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign count_next_o = count_d;

endmodule

// File: rtl/dac_table_8x_deadlock_watchdog.sv
// Persistence-qualified deadlock watchdog behind the dac_table_8x block monitor.
// Trips after 'timeout' consecutive blocked cycles, latches a sticky flag and stall snapshot.
module dac_table_8x_deadlock_watchdog
   import dac_table_8x_wd_pkg::*;
#(
   parameter int NUM_AXIS  = NUM_AXIS_DEF,
   parameter int TIMEOUT_W = TIMEOUT_W_DEF,
   parameter int EVT_W     = EVT_W_DEF
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic                 enable,
   input  logic [TIMEOUT_W-1:0] timeout,
   input  logic                 clear,
   input  logic                 block_in,
   input  logic [NUM_AXIS-1:0]  axis_block_sigs,
   output logic                 deadlock,
   output logic                 deadlock_irq,
   output logic [NUM_AXIS-1:0]  snapshot,
   output logic [TIMEOUT_W-1:0] run_len,
   output logic [TIMEOUT_W-1:0] max_run,
   output logic [EVT_W-1:0]     event_count
);

   wd_state_e            state_q, state_d;
   logic                 deadlock_q, deadlock_d;
   logic                 irq_q, irq_d;
   logic [NUM_AXIS-1:0]  snapshot_q, snapshot_d;
   logic [TIMEOUT_W-1:0] max_run_q, max_run_d;

   logic                 hit_s;
   logic                 trip_s;
   logic                 run_inc_s;
   logic                 run_clr_s;
   logic [TIMEOUT_W-1:0] run_len_s;
   logic [TIMEOUT_W-1:0] run_len_next_s;
   logic [EVT_W-1:0]     event_count_s;
   logic [EVT_W-1:0]     event_count_next_s;

   assign hit_s = enable & block_in;

   // Run-length counter control; once tripped only the raw block indication matters.
   always_comb begin
      run_inc_s = 1'b0;
      run_clr_s = 1'b0;
      case (state_q)
         IDLE, WATCH: begin
            if (clear) begin
               run_clr_s = 1'b1;
            end else if (hit_s) begin
               run_inc_s = 1'b1;
               run_clr_s = (state_q == IDLE);
            end else begin
               run_clr_s = 1'b1;
            end
         end
         TRIPPED: begin
            if (clear) begin
               run_clr_s = 1'b1;
            end else if (block_in) begin
               run_inc_s = 1'b1;
            end else begin
               run_inc_s = 1'b0;
            end
         end
         default: begin
            run_clr_s = 1'b1;
         end
      endcase
   end

   dac_table_8x_sat_counter #(
      .WIDTH (TIMEOUT_W)
   ) u_run_len (
      .clk_i        (ap_clk),
      .rst_n_i      (ap_rst_n),
      .inc_i        (run_inc_s),
      .clr_i        (run_clr_s),
      .count_o      (run_len_s),
      .count_next_o (run_len_next_s)
   );

   // Trip on the look-ahead count so a newly lowered timeout bites on the very next hit.
   always_comb begin
      state_d    = state_q;
      deadlock_d = deadlock_q;
      irq_d      = 1'b0;
      snapshot_d = snapshot_q;
      trip_s     = hit_s & ~clear & (state_q != TRIPPED)
                 & (timeout != {TIMEOUT_W{1'b0}}) & (run_len_next_s >= timeout);
      case (state_q)
         IDLE, WATCH: begin
            if (clear) begin
               state_d = IDLE;
            end else if (trip_s) begin
               state_d    = TRIPPED;
               deadlock_d = 1'b1;
               irq_d      = 1'b1;
               snapshot_d = axis_block_sigs;
            end else if (hit_s) begin
               state_d = WATCH;
            end else begin
               state_d = IDLE;
            end
         end
         TRIPPED: begin
            if (clear) begin
               state_d    = IDLE;
               deadlock_d = 1'b0;
               snapshot_d = {NUM_AXIS{1'b0}};
            end else begin
               state_d = TRIPPED;
            end
         end
         default: begin
            state_d    = IDLE;
            deadlock_d = 1'b0;
            snapshot_d = {NUM_AXIS{1'b0}};
         end
      endcase
      if (run_len_next_s > max_run_q) begin
         max_run_d = run_len_next_s;
      end else begin
         max_run_d = max_run_q;
      end
   end

   dac_table_8x_sat_counter #(
      .WIDTH (EVT_W)
   ) u_event_count (
      .clk_i        (ap_clk),
      .rst_n_i      (ap_rst_n),
      .inc_i        (trip_s),
      .clr_i        (1'b0),
      .count_o      (event_count_s),
      .count_next_o (event_count_next_s)
   );

   // State, sticky flag, irq pulse, snapshot and high-water mark registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= IDLE;
         deadlock_q <= 1'b0;
         irq_q      <= 1'b0;
         snapshot_q <= {NUM_AXIS{1'b0}};
         max_run_q  <= {TIMEOUT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         deadlock_q <= deadlock_d;
         irq_q      <= irq_d;
         snapshot_q <= snapshot_d;
         max_run_q  <= max_run_d;
      end
   end

   assign deadlock     = deadlock_q;
   assign deadlock_irq = irq_q;
   assign snapshot     = snapshot_q;
   assign run_len      = run_len_s;
   assign max_run      = max_run_q;
   assign event_count  = event_count_s;

   logic unused_s;
   assign unused_s = ^event_count_next_s;

endmodule

// File: tb/tb_dac_table_8x_deadlock_watchdog.sv
// Directed bench for the deadlock watchdog: a default-width instance plus a 4-bit instance
// used to reach run-length and event-count saturation in a short run.
module tb_dac_table_8x_deadlock_watchdog;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        enable, clear, block_in;
   logic [15:0] timeout;
   logic [2:0]  axis;
   logic        deadlock, irq;
   logic [2:0]  snapshot;
   logic [15:0] run_len, max_run;
   logic [7:0]  event_count;

   logic        s_enable, s_clear, s_block;
   logic [3:0]  s_timeout;
   logic [2:0]  s_axis;
   logic        s_deadlock, s_irq;
   logic [2:0]  s_snapshot;
   logic [3:0]  s_run_len, s_max_run;
   logic [7:0]  s_event_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dac_table_8x_deadlock_watchdog dut (
      .ap_clk          (clk),
      .ap_rst_n        (rst_n),
      .enable          (enable),
      .timeout         (timeout),
      .clear           (clear),
      .block_in        (block_in),
      .axis_block_sigs (axis),
      .deadlock        (deadlock),
      .deadlock_irq    (irq),
      .snapshot        (snapshot),
      .run_len         (run_len),
      .max_run         (max_run),
      .event_count     (event_count)
   );

   dac_table_8x_deadlock_watchdog #(
      .NUM_AXIS  (3),
      .TIMEOUT_W (4),
      .EVT_W     (8)
   ) dut_small (
      .ap_clk          (clk),
      .ap_rst_n        (rst_n),
      .enable          (s_enable),
      .timeout         (s_timeout),
      .clear           (s_clear),
      .block_in        (s_block),
      .axis_block_sigs (s_axis),
      .deadlock        (s_deadlock),
      .deadlock_irq    (s_irq),
      .snapshot        (s_snapshot),
      .run_len         (s_run_len),
      .max_run         (s_max_run),
      .event_count     (s_event_count)
   );

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         assert (!$isunknown(block_in)) else $error("block_in unknown out of reset");
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      enable    = 1'b0; clear   = 1'b0; block_in = 1'b0; timeout   = 16'd0; axis   = 3'd0;
      s_enable  = 1'b0; s_clear = 1'b0; s_block  = 1'b0; s_timeout = 4'd0;  s_axis = 3'd0;
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Power-on reset state
      do_reset();
      chk("por_deadlock", 32'(deadlock), 32'd0);
      chk("por_run_len", 32'(run_len), 32'd0);
      chk("por_event", 32'(event_count), 32'd0);

      // 1: async reset mid-WATCH
      enable = 1'b1; timeout = 16'd0; block_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t1_run_len_pre", 32'(run_len), 32'd5);
      chk("t1_max_run_pre", 32'(max_run), 32'd5);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_run_len", 32'(run_len), 32'd0);
      chk("t1_rst_max_run", 32'(max_run), 32'd0);
      chk("t1_rst_deadlock", 32'(deadlock), 32'd0);
      chk("t1_rst_irq", 32'(irq), 32'd0);
      chk("t1_rst_snapshot", 32'(snapshot), 32'd0);

      // 2: trip at timeout=4 with snapshot capture
      do_reset();
      enable = 1'b1; timeout = 16'd4; block_in = 1'b1; axis = 3'b010;
      for (int i = 0; i < 3; i++) tick();
      chk("t2_no_trip_yet", 32'(deadlock), 32'd0);
      chk("t2_run_len3", 32'(run_len), 32'd3);
      tick();
      chk("t2_deadlock", 32'(deadlock), 32'd1);
      chk("t2_irq", 32'(irq), 32'd1);
      chk("t2_snapshot", 32'(snapshot), 32'd2);
      chk("t2_event", 32'(event_count), 32'd1);
      axis = 3'b101; enable = 1'b0;
      tick();
      chk("t2_irq_low", 32'(irq), 32'd0);
      chk("t2_deadlock_sticky", 32'(deadlock), 32'd1);
      chk("t2_snapshot_held", 32'(snapshot), 32'd2);
      chk("t2_run_len_en_ignored", 32'(run_len), 32'd5);
      block_in = 1'b0;
      tick();
      chk("t2_run_len_hold", 32'(run_len), 32'd5);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t2_clr_deadlock", 32'(deadlock), 32'd0);
      chk("t2_clr_snapshot", 32'(snapshot), 32'd0);
      chk("t2_clr_run_len", 32'(run_len), 32'd0);
      chk("t2_event_kept", 32'(event_count), 32'd1);
      chk("t2_max_run_kept", 32'(max_run), 32'd5);

      // 3: near miss
      do_reset();
      enable = 1'b1; timeout = 16'd4; block_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      block_in = 1'b0;
      tick();
      chk("t3_deadlock", 32'(deadlock), 32'd0);
      chk("t3_run_len", 32'(run_len), 32'd0);
      chk("t3_max_run", 32'(max_run), 32'd3);
      chk("t3_event", 32'(event_count), 32'd0);

      // 4: clear races a would-be trip
      do_reset();
      enable = 1'b1; timeout = 16'd2; block_in = 1'b1;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_race_deadlock", 32'(deadlock), 32'd0);
      chk("t4_race_irq", 32'(irq), 32'd0);
      chk("t4_race_run_len", 32'(run_len), 32'd0);
      tick();
      chk("t4_resume_run_len", 32'(run_len), 32'd1);
      chk("t4_resume_deadlock", 32'(deadlock), 32'd0);
      tick();
      chk("t4_trip_deadlock", 32'(deadlock), 32'd1);
      chk("t4_trip_irq", 32'(irq), 32'd1);
      chk("t4_event", 32'(event_count), 32'd1);

      // timeout=1 trips straight from IDLE
      do_reset();
      enable = 1'b1; timeout = 16'd1; block_in = 1'b1; axis = 3'b100;
      tick();
      chk("t1c_deadlock", 32'(deadlock), 32'd1);
      chk("t1c_irq", 32'(irq), 32'd1);
      chk("t1c_snapshot", 32'(snapshot), 32'd4);

      // timeout lowered below the current run length mid-WATCH
      do_reset();
      enable = 1'b1; timeout = 16'd10; block_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("tchg_no_trip", 32'(deadlock), 32'd0);
      timeout = 16'd3;
      tick();
      chk("tchg_trip", 32'(deadlock), 32'd1);
      chk("tchg_run_len", 32'(run_len), 32'd6);

      // enable dropped in WATCH
      do_reset();
      enable = 1'b1; timeout = 16'd8; block_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      enable = 1'b0;
      tick();
      chk("ten_run_len", 32'(run_len), 32'd0);
      chk("ten_deadlock", 32'(deadlock), 32'd0);

      // 5: timeout=0 never trips
      do_reset();
      enable = 1'b1; timeout = 16'd0; block_in = 1'b1;
      for (int i = 0; i < 1000; i++) tick();
      chk("t5_deadlock", 32'(deadlock), 32'd0);
      chk("t5_run_len", 32'(run_len), 32'd1000);
      chk("t5_max_run", 32'(max_run), 32'd1000);

      // 6: saturation on the narrow instance
      do_reset();
      s_enable = 1'b1; s_timeout = 4'd0; s_block = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      chk("t6_run_len_sat", 32'(s_run_len), 32'd15);
      chk("t6_max_run_sat", 32'(s_max_run), 32'd15);
      chk("t6_no_trip", 32'(s_deadlock), 32'd0);
      s_timeout = 4'd1;
      for (int i = 0; i < 300; i++) begin
         s_block = 1'b1;
         tick();
         s_block = 1'b0;
         s_clear = 1'b1;
         tick();
         s_clear = 1'b0;
      end
      chk("t6_event_sat", 32'(s_event_count), 32'd255);
      chk("t6_deadlock_cleared", 32'(s_deadlock), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
